montprod_arbiter: RTL
=====================

MONTPROD_ARBITER -- requirements
Module: montprod_arbiter

Interface
REQ-001 Parameter BITS, default 64, sets the operand and result width.
REQ-002 Parameter NREQ, default 4, sets the number of requesters; range 2..8.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 req  input  NREQ  per-requester request level; bit k = requester k.
REQ-006 a_in  input  NREQ*BITS  operand A; slice [k*BITS +: BITS] belongs to requester k.
REQ-007 b_in  input  NREQ*BITS  operand B; same slicing as a_in.
REQ-008 m_in  input  BITS  shared odd modulus.
REQ-009 gnt  output  NREQ  one-hot grant; held for the whole service of one job.
REQ-010 rsp_valid  output  NREQ  one-cycle pulse on the bit of the served requester.
REQ-011 rsp_s  output  BITS  result of the last job; stable until the next rsp_valid.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 mm_go  output  1  multiplier start level.
REQ-014 mm_a, mm_b, mm_m  output  BITS each  registered operands and modulus to the multiplier.
REQ-015 mm_done  input  1  multiplier done level.
REQ-016 mm_s  input  BITS  multiplier result; valid while mm_done=1.

Function
REQ-017 Shares one Montgomery multiplier among NREQ requesters.
- Multiplier protocol: mm_go is held high until mm_done=1.
- mm_go is then dropped.
- No new job is issued until mm_done has returned to 0.
REQ-018 FSM has three states, one-hot encoded: IDLE, RUN, DRAIN.
REQ-019 IDLE, when |req=1 and mm_done=0, in one registered cycle:
- pick winner idx by round-robin, searching from ptr upward with wrap at NREQ-1 -> 0;
- load mm_a/mm_b from slice idx, and mm_m <= m_in;
- set gnt[idx], mm_go <= 1;
- go to RUN.
REQ-020 Latency: req sampled at edge t -> gnt and mm_go high after edge t+1.
REQ-021 RUN:
- mm_go, mm_a, mm_b, mm_m and gnt are held constant.
- On mm_done=1: rsp_s <= mm_s, rsp_valid[idx] <= 1 for exactly one cycle, mm_go <= 0, go to DRAIN.
REQ-022 DRAIN:
- mm_go=0; gnt still held.
- When mm_done=0: ptr <= (idx+1) mod NREQ, gnt <= 0, go to IDLE.
- Minimum one DRAIN cycle.
REQ-023 req is ignored in RUN and DRAIN.
- Deasserting req mid-job does not abort it; the result and rsp_valid are still delivered.
REQ-024 Requester k deasserts req[k] no later than the cycle after its rsp_valid[k] pulse.
- A req still high in IDLE is a new job.
REQ-025 Operands and m_in are sampled only at grant; later changes do not affect the running job.
REQ-026 With all req bits continuously high, the service order is 0,1,...,NREQ-1,0,...
- No requester waits more than NREQ-1 jobs.
REQ-027 IDLE does not issue while mm_done=1, e.g. a multiplier still finishing after a reset.
REQ-028 rsp_valid is never asserted on more than one bit in any cycle.
REQ-029 gnt has at most one bit set at any time.

Reset
REQ-030 rst=1 at a clock edge sets, from the next cycle:
- state=IDLE, ptr=0;
- gnt=0, rsp_valid=0, rsp_s=0, busy=0;
- mm_go=0, mm_a=mm_b=mm_m=0.
REQ-031 Reset overrides every state.
- A job in RUN or DRAIN is aborted with no rsp_valid.
REQ-032 While rst=1, req is ignored.

Verification
Bench uses a multiplier model: mm_done rises 66 cycles after mm_go rises, and falls 1 cycle after mm_go falls.
REQ-033 req=0001, a_in[0]=3, b_in[0]=5, m_in=0xFFFFFFFFFFFFFFC5
- -> gnt=0001 and mm_go=1 one cycle later;
- -> rsp_valid=0001 for one cycle with rsp_s=model(3,5,M);
- -> busy=0 after DRAIN.
REQ-034 req=1111 held, distinct operands per requester
- -> grants 0001,0010,0100,1000,0001 in that order;
- -> each rsp_s matches its own requester's operands.
REQ-035 After serving requester 2 (ptr=3), req=1001
- -> requester 3 is served first, then requester 0.
REQ-036 rst=1 for one cycle at RUN cycle 20
- -> next cycle gnt=0, mm_go=0, rsp_valid never pulses;
- -> with req=0010 and mm_done held high by the model, no mm_go until mm_done=0.
REQ-037 req[1] dropped 2 cycles after grant, a_in[1] changed during RUN
- -> rsp_valid=0010 still pulses;
- -> rsp_s equals the result for the operands sampled at grant.

Source files
------------

// File: rtl/montprod_arbiter.sv
// rtl/montprod_arbiter.sv - round-robin arbiter sharing one Montgomery multiplier
// Each requester gets one full go/done/drain handshake per job; the pointer moves past the last winner.
module montprod_arbiter #(
   parameter int BITS = 64,
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*BITS-1:0] a_in,
   input  logic [NREQ*BITS-1:0] b_in,
   input  logic [BITS-1:0]      m_in,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [BITS-1:0]      rsp_s,
   output logic                 busy,
   output logic                 mm_go,
   output logic [BITS-1:0]      mm_a,
   output logic [BITS-1:0]      mm_b,
   output logic [BITS-1:0]      mm_m,
   input  logic                 mm_done,
   input  logic [BITS-1:0]      mm_s
);

   localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'b001,
      S_RUN   = 3'b010,
      S_DRAIN = 3'b100
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_idx;
   logic [NREQ-1:0] r_gnt;
   logic [NREQ-1:0] r_rsp_valid;
   logic [BITS-1:0] r_rsp_s;
   logic            r_mm_go;
   logic [BITS-1:0] r_mm_a;
   logic [BITS-1:0] r_mm_b;
   logic [BITS-1:0] r_mm_m;

   logic [IW-1:0]   w_win;
   logic [NREQ-1:0] w_win_onehot;
   logic [BITS-1:0] w_a;
   logic [BITS-1:0] w_b;

   // Scan offsets from the far end down so the smallest offset from r_ptr wins.
   function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
      logic [IW-1:0] win;
      int            c;
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         c = int'(p) + i;
         if (c >= NREQ) c = c - NREQ;
         if (r[IW'(c)]) win = IW'(c);
      end
      return win;
   endfunction

   always_comb begin
      w_win        = rr_pick(req, r_ptr);
      w_win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
      w_a          = '0;
      w_b          = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_win == IW'(k)) begin
            w_a = a_in[k*BITS +: BITS];
            w_b = b_in[k*BITS +: BITS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_idx       <= '0;
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_s     <= '0;
         r_mm_go     <= 1'b0;
         r_mm_a      <= '0;
         r_mm_b      <= '0;
         r_mm_m      <= '0;
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            S_IDLE: begin
               // A multiplier still raising done from an earlier job blocks new issue.
               if (|req && !mm_done) begin
                  r_idx   <= w_win;
                  r_gnt   <= w_win_onehot;
                  r_mm_a  <= w_a;
                  r_mm_b  <= w_b;
                  r_mm_m  <= m_in;
                  r_mm_go <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (mm_done) begin
                  r_rsp_s     <= mm_s;
                  r_rsp_valid <= r_gnt;
                  r_mm_go     <= 1'b0;
                  r_state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!mm_done) begin
                  r_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                  r_gnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign rsp_valid = r_rsp_valid;
   assign rsp_s     = r_rsp_s;
   assign busy      = (r_state != S_IDLE);
   assign mm_go     = r_mm_go;
   assign mm_a      = r_mm_a;
   assign mm_b      = r_mm_b;
   assign mm_m      = r_mm_m;

endmodule
